// File: rtl/sos_trigger_arbiter_pkg.sv
// Shared types and helpers for the SOS trigger arbiter family.
// State encoding and constant-time width helpers.
package sos_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sos_trigger_arbiter_rr_arbiter.sv
// Combinational request arbiter: round-robin after 'last' (mode=1) or lowest index (mode=0).
// Zero latency; no flow control, grant is all-zero when req is empty.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last,
    input  logic            mode,
    output logic [N_CH-1:0] grant_onehot,
    output logic [CH_W-1:0] grant_idx
);

    logic            w_found;
    logic [CH_W-1:0] w_cand;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        w_found      = 1'b0;
        w_cand       = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cand = mode ? CH_W'((int'(last) + 1 + i) % N_CH) : CH_W'(i);
            if (!w_found && req[w_cand]) begin
                w_found              = 1'b1;
                grant_onehot[w_cand] = 1'b1;
                grant_idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/sos_trigger_arbiter.sv
// Queues one request per trigger channel, arbitrates, and issues a PULSE_W-wide SOS enable.
// Grant one cycle after a request is seen; waits for Done (optional timeout) then holds off.
module sos_trigger_arbiter
    import sos_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CH_W      = (N_CH > 1) ? clog2(N_CH) : 1,
    parameter int PULSE_W   = 1,
    parameter int HOLD_CYC  = 0,
    parameter int TIMEOUT   = 0,
    parameter int EDGE_MODE = 1,
    parameter int ARB_RR    = 1
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [N_CH-1:0] Trig_Sig,
    input  logic            Done_Sig,
    input  logic            Clear_Sig,
    output logic            SOS_En_Sig,
    output logic [CH_W-1:0] Ch_Id,
    output logic            Busy_Sig,
    output logic [N_CH-1:0] Pend_Mask,
    output logic            Tmo_Sig
);

    localparam int              CNT_W       = clog2(max3(PULSE_W, HOLD_CYC, TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] C_PULSE_END = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] C_HOLD_END  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] C_TMO_END   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CH_W-1:0]  C_LAST_RST  = CH_W'(N_CH - 1);
    localparam logic             C_HOLD_EN   = (HOLD_CYC > 0);
    localparam logic             C_TMO_EN    = (TIMEOUT > 0);
    localparam logic             C_EDGE      = (EDGE_MODE != 0);
    localparam logic             C_RR        = (ARB_RR != 0);

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N_CH-1:0] r_trig_d;
    logic [N_CH-1:0] r_pend;
    logic [CH_W-1:0] r_rr_last;
    logic [CH_W-1:0] r_ch;
    logic            r_sos;
    logic            r_tmo;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [N_CH-1:0] w_req_new;
    logic [N_CH-1:0] w_req;
    logic [N_CH-1:0] w_arb_onehot;
    logic [CH_W-1:0] w_arb_idx;
    logic [N_CH-1:0] w_grant_mask;
    logic            w_grant_vld;
    logic [N_CH-1:0] w_pend_nxt;
    logic [CH_W-1:0] w_ch_nxt;
    logic [CH_W-1:0] w_last_nxt;
    logic            w_sos_nxt;
    logic            w_tmo_nxt;
    logic            w_seq_end;

    assign w_req_new    = C_EDGE ? (Trig_Sig & ~r_trig_d) : Trig_Sig;
    assign w_req        = r_pend | w_req_new;
    assign w_grant_vld  = (r_state == ST_IDLE) && !Clear_Sig && (|w_req);
    assign w_grant_mask = w_grant_vld ? w_arb_onehot : '0;
    // Clear dominates any request arriving in the same cycle.
    assign w_pend_nxt   = Clear_Sig ? '0 : (w_req & ~w_grant_mask);
    assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req          (w_req),
        .last         (r_rr_last),
        .mode         (C_RR),
        .grant_onehot (w_arb_onehot),
        .grant_idx    (w_arb_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_ch_nxt    = r_ch;
        w_last_nxt  = r_rr_last;
        w_sos_nxt   = r_sos;
        w_tmo_nxt   = 1'b0;
        w_seq_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = '0;
                    w_ch_nxt    = w_arb_idx;
                    w_last_nxt  = w_arb_idx;
                    w_sos_nxt   = 1'b1;
                end
            end
            ST_PULSE: begin
                if (r_cnt == C_PULSE_END) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = '0;
                    w_sos_nxt   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (Done_Sig) begin
                    w_seq_end = 1'b1;
                end else if (C_TMO_EN && (r_cnt == C_TMO_END)) begin
                    w_tmo_nxt = 1'b1;
                    w_seq_end = 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == C_HOLD_END) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_seq_end) begin
            w_state_nxt = C_HOLD_EN ? ST_HOLD : ST_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_trig_d  <= '0;
            r_pend    <= '0;
            r_rr_last <= C_LAST_RST;
            r_ch      <= '0;
            r_sos     <= 1'b0;
            r_tmo     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_trig_d  <= Trig_Sig;
            r_pend    <= w_pend_nxt;
            r_rr_last <= w_last_nxt;
            r_ch      <= w_ch_nxt;
            r_sos     <= w_sos_nxt;
            r_tmo     <= w_tmo_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign SOS_En_Sig = r_sos;
    assign Ch_Id      = r_ch;
    assign Busy_Sig   = r_busy;
    assign Pend_Mask  = r_pend;
    assign Tmo_Sig    = r_tmo;

endmodule

// File: tb/tb_sos_trigger_arbiter.sv
// Bench: edge-mode and level-mode instances share stimulus; a phase-level model predicts both.
module tb_sos_trigger_arbiter;

    localparam int N   = 4;
    localparam int PW  = 3;
    localparam int HC  = 5;
    localparam int TMO = 20;

    localparam int P_IDLE  = 0;
    localparam int P_PULSE = 1;
    localparam int P_WAIT  = 2;
    localparam int P_HOLD  = 3;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic [3:0] Trig;
    logic       Done;
    logic       Clear;
    logic [1:0] sos, busy, tmo;
    logic [1:0] ch   [2];
    logic [3:0] pend [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    sos_trigger_arbiter #(
        .N_CH(4), .CH_W(2), .PULSE_W(PW), .HOLD_CYC(HC), .TIMEOUT(TMO), .EDGE_MODE(1), .ARB_RR(1)
    ) u_dut_edge (
        .CLK(CLK), .RSTn(RSTn), .Trig_Sig(Trig), .Done_Sig(Done), .Clear_Sig(Clear),
        .SOS_En_Sig(sos[0]), .Ch_Id(ch[0]), .Busy_Sig(busy[0]), .Pend_Mask(pend[0]), .Tmo_Sig(tmo[0])
    );

    sos_trigger_arbiter #(
        .N_CH(4), .CH_W(2), .PULSE_W(PW), .HOLD_CYC(HC), .TIMEOUT(TMO), .EDGE_MODE(0), .ARB_RR(1)
    ) u_dut_lvl (
        .CLK(CLK), .RSTn(RSTn), .Trig_Sig(Trig), .Done_Sig(Done), .Clear_Sig(Clear),
        .SOS_En_Sig(sos[1]), .Ch_Id(ch[1]), .Busy_Sig(busy[1]), .Pend_Mask(pend[1]), .Tmo_Sig(tmo[1])
    );

    always #5 CLK = ~CLK;

    // Model index 0 uses edge requests, index 1 level requests.
    logic [3:0] m_trig_d [2];
    logic [3:0] m_pend   [2];
    int         m_phase  [2];
    int         m_left   [2];
    int         m_age    [2];
    int         m_ch     [2];
    int         m_last   [2];
    bit         m_en     [2];
    bit         m_tmo    [2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pin(input string name, input int act, input int mdl, input int lit);
        chk(name, act, lit);
        chk({name, "_model"}, mdl, lit);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_trig_d[m] = '0;
            m_pend[m]   = '0;
            m_phase[m]  = P_IDLE;
            m_left[m]   = 0;
            m_age[m]    = 0;
            m_ch[m]     = 0;
            m_last[m]   = N - 1;
            m_en[m]     = 1'b0;
            m_tmo[m]    = 1'b0;
        end
    endtask

    task automatic finish_seq(input int m);
        if (HC > 0) begin
            m_phase[m] = P_HOLD;
            m_left[m]  = HC;
        end else begin
            m_phase[m] = P_IDLE;
        end
    endtask

    task automatic model_step(input int m);
        logic [3:0] fresh, req;
        int win, c;
        fresh = (m == 0) ? (Trig & ~m_trig_d[m]) : Trig;
        m_trig_d[m] = Trig;
        req = m_pend[m] | fresh;
        win = -1;
        if (m_phase[m] == P_IDLE && req != 0 && !Clear) begin
            for (int i = 1; i <= N; i++) begin
                c = (m_last[m] + i) % N;
                if (win < 0 && req[c[1:0]]) win = c;
            end
        end
        m_pend[m] = Clear ? 4'b0 : req;
        if (win >= 0) m_pend[m] = m_pend[m] & ~(4'b0001 << win);
        m_tmo[m] = 1'b0;
        case (m_phase[m])
            P_IDLE: if (win >= 0) begin
                m_ch[m] = win; m_last[m] = win; m_en[m] = 1'b1;
                m_phase[m] = P_PULSE; m_left[m] = PW;
            end
            P_PULSE: begin
                m_left[m]--;
                if (m_left[m] == 0) begin
                    m_en[m] = 1'b0; m_phase[m] = P_WAIT; m_age[m] = 0;
                end
            end
            P_WAIT: begin
                m_age[m]++;
                if (Done) finish_seq(m);
                else if (TMO > 0 && m_age[m] == TMO) begin
                    m_tmo[m] = 1'b1;
                    finish_seq(m);
                end
            end
            default: begin
                m_left[m]--;
                if (m_left[m] == 0) m_phase[m] = P_IDLE;
            end
        endcase
    endtask

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) model_reset();
        else for (int m = 0; m < 2; m++) model_step(m);
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("sos_en[%0d]", m), sos[m], m_en[m]);
                chk($sformatf("ch_id[%0d]", m), ch[m], m_ch[m]);
                chk($sformatf("busy[%0d]", m), busy[m], (m_phase[m] != P_IDLE));
                chk($sformatf("pend[%0d]", m), pend[m], m_pend[m]);
                chk($sformatf("tmo[%0d]", m), tmo[m], m_tmo[m]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RSTn = 1'b0; Trig = '0; Done = 1'b0; Clear = 1'b0;
        tick(2);
        chk_en = 1'b1;
        pin("rst_sos", sos[0], m_en[0], 0);
        pin("rst_busy", busy[0], (m_phase[0] != P_IDLE), 0);
        pin("rst_pend", pend[0], m_pend[0], 0);
        pin("rst_ch", ch[0], m_ch[0], 0);
        pin("rst_tmo", tmo[0], m_tmo[0], 0);
        RSTn = 1'b1;
    endtask

    task automatic serve_expect(input int exp, input logic [3:0] retrig);
        int n;
        n = 0;
        while (!sos[0] && n < 60) begin tick(1); n++; end
        chk($sformatf("grant_seen_ch%0d", exp), sos[0], 1);
        chk($sformatf("grant_order_ch%0d", exp), ch[0], exp);
        if (retrig != 0) begin Trig = retrig; tick(1); Trig = '0; end
        n = 0;
        while (sos[0] && n < 10) begin tick(1); n++; end
        Done = 1'b1; tick(1); Done = 1'b0;
    endtask

    initial begin
        int r0, r1, rm0, rm1;
        bit p0, p1, pm0, pm1;

        do_reset();

        // Single trigger on channel 2
        Trig = 4'b0100; tick(1); Trig = '0;
        pin("s1_sos_k1", sos[0], m_en[0], 1);
        pin("s1_ch", ch[0], m_ch[0], 2);
        pin("s1_busy", busy[0], (m_phase[0] != P_IDLE), 1);
        tick(2);
        pin("s1_sos_k3", sos[0], m_en[0], 1);
        tick(1);
        pin("s1_sos_k4", sos[0], m_en[0], 0);
        tick(2); Done = 1'b1; tick(1); Done = 1'b0;
        tick(4);
        pin("s1_busy_hold", busy[0], (m_phase[0] != P_IDLE), 1);
        tick(1);
        pin("s1_busy_end", busy[0], (m_phase[0] != P_IDLE), 0);
        pin("s1_pend", pend[0], m_pend[0], 0);

        // Simultaneous triggers and round-robin order
        do_reset();
        Trig = 4'b1010; tick(1); Trig = '0;
        pin("s2_first_ch", ch[0], m_ch[0], 1);
        pin("s2_pend", pend[0], m_pend[0], 8);
        tick(3); Done = 1'b1; tick(1); Done = 1'b0;
        tick(5);
        pin("s2_idle_gap", busy[0], (m_phase[0] != P_IDLE), 0);
        tick(1);
        pin("s2_second_ch", ch[0], m_ch[0], 3);
        pin("s2_second_sos", sos[0], m_en[0], 1);
        Trig = 4'b1111; tick(1); Trig = '0;
        pin("s2_pend_all", pend[0], m_pend[0], 15);
        serve_expect(3, 4'b0000);
        serve_expect(0, 4'b0000);
        serve_expect(1, 4'b0001);
        serve_expect(2, 4'b0000);
        serve_expect(3, 4'b0000);
        serve_expect(0, 4'b0000);

        // Trig[0] held for 100 cycles, Done held as a level
        do_reset();
        r0 = 0; r1 = 0; rm0 = 0; rm1 = 0;
        p0 = 0; p1 = 0; pm0 = 0; pm1 = 0;
        Done = 1'b1; Trig = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (sos[0] && !p0) r0++;
            if (sos[1] && !p1) r1++;
            if (m_en[0] && !pm0) rm0++;
            if (m_en[1] && !pm1) rm1++;
            p0 = sos[0]; p1 = sos[1]; pm0 = m_en[0]; pm1 = m_en[1];
        end
        Trig = '0; Done = 1'b0;
        pin("s3_edge_grants", r0, rm0, 1);
        pin("s3_level_grants", r1, rm1, 10);

        // No Done: timeout, holdoff, then queued channel 1
        do_reset();
        Trig = 4'b0100; tick(1);
        Trig = 4'b0010; tick(1); Trig = '0;
        pin("s4_pend", pend[0], m_pend[0], 2);
        tick(21);
        pin("s4_tmo_early", tmo[0], m_tmo[0], 0);
        tick(1);
        pin("s4_tmo_pulse", tmo[0], m_tmo[0], 1);
        tick(1);
        pin("s4_tmo_drop", tmo[0], m_tmo[0], 0);
        pin("s4_hold_busy", busy[0], (m_phase[0] != P_IDLE), 1);
        tick(4);
        pin("s4_idle", busy[0], (m_phase[0] != P_IDLE), 0);
        tick(1);
        pin("s4_queued_sos", sos[0], m_en[0], 1);
        pin("s4_queued_ch", ch[0], m_ch[0], 1);

        // Clear while serving channel 0
        do_reset();
        Trig = 4'b0001; tick(1);
        Trig = 4'b0110; tick(1); Trig = '0;
        pin("s5_pend_set", pend[0], m_pend[0], 6);
        Clear = 1'b1; tick(1); Clear = 1'b0;
        pin("s5_pend_clr", pend[0], m_pend[0], 0);
        Clear = 1'b1; Trig = 4'b1000; tick(1); Clear = 1'b0; Trig = '0;
        pin("s5_clear_wins", pend[0], m_pend[0], 0);
        Done = 1'b1; tick(1); Done = 1'b0;
        tick(8);
        pin("s5_no_grant", sos[0], m_en[0], 0);
        pin("s5_idle", busy[0], (m_phase[0] != P_IDLE), 0);

        // Reset during the second pulse cycle
        do_reset();
        Trig = 4'b0010; tick(1);
        Trig = 4'b0100; tick(1); Trig = '0;
        pin("s6_pend_before", pend[0], m_pend[0], 4);
        RSTn = 1'b0; #1;
        pin("s6_rst_sos", sos[0], m_en[0], 0);
        pin("s6_rst_busy", busy[0], (m_phase[0] != P_IDLE), 0);
        pin("s6_rst_pend", pend[0], m_pend[0], 0);
        tick(2); RSTn = 1'b1; tick(1);
        pin("s6_quiet", sos[0], m_en[0], 0);
        Trig = 4'b1000; tick(1); Trig = '0;
        pin("s6_regrant_sos", sos[0], m_en[0], 1);
        pin("s6_regrant_ch", ch[0], m_ch[0], 3);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                RSTn = 1'b0; tick(1); RSTn = 1'b1;
            end else begin
                for (int b = 0; b < N; b++)
                    if ($urandom_range(0, 7) == 0) Trig[b] = ~Trig[b];
                Done  = ($urandom_range(0, 11) == 0);
                Clear = ($urandom_range(0, 59) == 0);
                tick(1);
            end
        end
        Trig = '0; Done = 1'b0; Clear = 1'b0;
        tick(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
